// File: rtl/phy_rx_serial_to_parallel.sv
// rtl/phy_rx_serial_to_parallel.sv - PCIe RX lane deserializer with COM alignment
// Locks byte alignment after COM_COUNT aligned COMs, then emits each byte held for 8 bit clocks.
module phy_rx_serial_to_parallel #(
  parameter logic [7:0]  COM_SYMBOL = 8'hBC,
  parameter int unsigned COM_COUNT  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  typedef enum logic [1:0] {SEARCH, ALIGN, ACTIVE} state_e;

  localparam logic [3:0] COM_TARGET = 4'(COM_COUNT);

  state_e      state_q, state_d;
  logic [6:0]  sr_q;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  com_cnt_q, com_cnt_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;

  logic [7:0]  win;
  logic        boundary;
  logic        is_com;

  // Byte ending with the bit being sampled on this edge.
  assign win      = {sr_q, data_in};
  assign boundary = (bit_cnt_q == 3'd7);
  assign is_com   = (win == COM_SYMBOL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= SEARCH;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      com_cnt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= win[6:0];
      bit_cnt_q <= bit_cnt_d;
      com_cnt_q <= com_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    com_cnt_d = com_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    case (state_q)
      SEARCH: begin
        if (is_com) begin
          bit_cnt_d = 3'd0;
          com_cnt_d = 4'd1;
          state_d   = (COM_TARGET == 4'd1) ? ACTIVE : ALIGN;
        end
      end
      ALIGN: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          if (is_com) begin
            com_cnt_d = com_cnt_q + 4'd1;
            if (com_cnt_q + 4'd1 == COM_TARGET) state_d = ACTIVE;
          end else begin
            // The failing edge itself is not searched; hunting resumes next edge.
            com_cnt_d = 4'd0;
            state_d   = SEARCH;
          end
        end
      end
      ACTIVE: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          data_d  = win;
          valid_d = !is_com;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign active    = (state_q == ACTIVE);

endmodule

// File: tb/tb_phy_rx_serial_to_parallel.sv
// tb/tb_phy_rx_serial_to_parallel.sv - self-checking bench for phy_rx_serial_to_parallel
// Bit streams are scored edge by edge against an array-scan model of the alignment rules.
module tb_phy_rx_serial_to_parallel;

  localparam logic [7:0] BC = 8'hBC;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       data_in0 = 1'b0, data_in1 = 1'b0;
  logic [7:0] data_out0, data_out1;
  logic       valid_out0, valid_out1, active0, active1;

  int checks = 0;
  int failures = 0;

  bit         stim[$];
  logic       obs_act[$], obs_v[$], exp_act[$], exp_v[$];
  logic [7:0] obs_d[$], exp_d[$];
  int         lock_edge;

  always #5 clk = ~clk;

  phy_rx_serial_to_parallel #(.COM_SYMBOL(8'hBC), .COM_COUNT(4)) dut (
    .clk(clk), .reset(reset), .data_in(data_in0),
    .data_out(data_out0), .valid_out(valid_out0), .active(active0));

  phy_rx_serial_to_parallel #(.COM_SYMBOL(8'hBC), .COM_COUNT(1)) dut1 (
    .clk(clk), .reset(reset), .data_in(data_in1),
    .data_out(data_out1), .valid_out(valid_out1), .active(active1));

  task automatic push_byte(input logic [7:0] b);
    for (int j = 7; j >= 0; j--) stim.push_back(b[j]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    data_in0 = 1'b0;
    data_in1 = 1'b0;
    #1 reset = 1'b0;
  endtask

  task automatic drive(input int sel);
    obs_act.delete(); obs_d.delete(); obs_v.delete();
    for (int i = 0; i < stim.size(); i++) begin
      if (sel == 0) data_in0 = stim[i]; else data_in1 = stim[i];
      @(posedge clk);
      #1;
      if (sel == 0) begin
        obs_act.push_back(active0); obs_d.push_back(data_out0); obs_v.push_back(valid_out0);
      end else begin
        obs_act.push_back(active1); obs_d.push_back(data_out1); obs_v.push_back(valid_out1);
      end
    end
  endtask

  function automatic logic [7:0] win_at(input int i);
    logic [7:0] r = 8'h00;
    for (int j = i - 7; j <= i; j++) r = {r[6:0], (j >= 0) ? stim[j] : 1'b0};
    return r;
  endfunction

  // Scan: find a COM, then demand cc-1 more COMs every 8 bits; a miss resumes one bit later.
  function automatic void run_model(input int cc);
    int n = stim.size();
    int i = 0;
    int k;
    logic [7:0] d = 8'h00;
    logic v = 1'b0;
    lock_edge = -1;
    while (i < n && lock_edge < 0) begin
      if (win_at(i) == BC) begin
        k = 1;
        while (k < cc && i + 8 * k < n && win_at(i + 8 * k) == BC) k++;
        if (k == cc) lock_edge = i + 8 * (cc - 1);
        else if (i + 8 * k >= n) break;
        else i = i + 8 * k + 1;
      end else begin
        i++;
      end
    end
    exp_act.delete(); exp_d.delete(); exp_v.delete();
    for (int e = 0; e < n; e++) begin
      if (lock_edge >= 0 && e > lock_edge && (e - lock_edge) % 8 == 0) begin
        d = win_at(e);
        v = (d != BC);
      end
      exp_act.push_back(lock_edge >= 0 && e >= lock_edge);
      exp_d.push_back(d);
      exp_v.push_back(v);
    end
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if (data_out0 !== 8'h00 || valid_out0 !== 1'b0 || active0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_initial: got d=%h v=%b a=%b, want d=00 v=0 a=0", data_out0, valid_out0, active0);
    end
    do_reset();
    stim.delete();
    repeat (4) push_byte(BC);
    push_byte(8'hA5);
    push_byte(8'h3C);
    drive(0);
    checks++;
    if (obs_v[43] !== 1'b1 || obs_d[43] !== 8'hA5) begin
      failures++;
      $display("FAIL reset_prelock: got d=%h v=%b, want d=a5 v=1", obs_d[43], obs_v[43]);
    end
    // Mid-bit reset while ACTIVE with a valid byte out: must clear without a clock edge.
    #2 reset = 1'b1;
    #1;
    checks++;
    if (data_out0 !== 8'h00 || valid_out0 !== 1'b0 || active0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: got d=%h v=%b a=%b, want d=00 v=0 a=0", data_out0, valid_out0, active0);
    end
    reset = 1'b0;
  endtask

  task automatic test_lock_offset3();
    do_reset();
    stim.delete();
    stim.push_back(1'b1); stim.push_back(1'b0); stim.push_back(1'b1);
    repeat (4) push_byte(BC);
    push_byte(8'h5A);
    push_byte(8'($urandom));
    drive(0);
    run_model(4);
    for (int e = 0; e < stim.size(); e++) begin
      checks++;
      if (obs_act[e] !== exp_act[e] || obs_d[e] !== exp_d[e] || obs_v[e] !== exp_v[e]) begin
        failures++;
        $display("FAIL lock3 edge %0d: got a=%b d=%h v=%b, want a=%b d=%h v=%b", e, obs_act[e], obs_d[e], obs_v[e], exp_act[e], exp_d[e], exp_v[e]);
      end
    end
    checks++;
    if (obs_act[33] !== 1'b0 || obs_act[34] !== 1'b1) begin
      failures++;
      $display("FAIL lock3_rise: got a33=%b a34=%b, want 0 1", obs_act[33], obs_act[34]);
    end
    for (int e = 42; e <= 49; e++) begin
      checks++;
      if (obs_d[e] !== 8'h5A || obs_v[e] !== 1'b1) begin
        failures++;
        $display("FAIL lock3_hold edge %0d: got d=%h v=%b, want d=5a v=1", e, obs_d[e], obs_v[e]);
      end
    end
  endtask

  task automatic test_broken_alignment();
    do_reset();
    stim.delete();
    push_byte(BC); push_byte(BC); push_byte(8'h00);
    repeat (4) push_byte(BC);
    push_byte(8'h3C);
    push_byte(8'h77);
    drive(0);
    run_model(4);
    for (int e = 0; e < stim.size(); e++) begin
      checks++;
      if (obs_act[e] !== exp_act[e] || obs_d[e] !== exp_d[e] || obs_v[e] !== exp_v[e]) begin
        failures++;
        $display("FAIL broken edge %0d: got a=%b d=%h v=%b, want a=%b d=%h v=%b", e, obs_act[e], obs_d[e], obs_v[e], exp_act[e], exp_d[e], exp_v[e]);
      end
    end
    checks++;
    if (obs_act[23] !== 1'b0 || obs_act[54] !== 1'b0 || obs_act[55] !== 1'b1 || obs_d[63] !== 8'h3C || obs_v[63] !== 1'b1) begin
      failures++;
      $display("FAIL broken_key: got a23=%b a54=%b a55=%b d63=%h v63=%b, want 0 0 1 3c 1", obs_act[23], obs_act[54], obs_act[55], obs_d[63], obs_v[63]);
    end
  endtask

  task automatic test_com_strip();
    do_reset();
    stim.delete();
    repeat (4) push_byte(BC);
    push_byte(8'h11); push_byte(BC); push_byte(8'h22); push_byte(8'h00);
    drive(0);
    run_model(4);
    for (int e = 0; e < stim.size(); e++) begin
      checks++;
      if (obs_act[e] !== exp_act[e] || obs_d[e] !== exp_d[e] || obs_v[e] !== exp_v[e]) begin
        failures++;
        $display("FAIL strip edge %0d: got a=%b d=%h v=%b, want a=%b d=%h v=%b", e, obs_act[e], obs_d[e], obs_v[e], exp_act[e], exp_d[e], exp_v[e]);
      end
    end
    checks++;
    if (obs_d[39] !== 8'h11 || obs_v[39] !== 1'b1 || obs_d[47] !== BC || obs_v[47] !== 1'b0 || obs_d[55] !== 8'h22 || obs_v[55] !== 1'b1) begin
      failures++;
      $display("FAIL strip_key: got %h/%b %h/%b %h/%b, want 11/1 bc/0 22/1", obs_d[39], obs_v[39], obs_d[47], obs_v[47], obs_d[55], obs_v[55]);
    end
  endtask

  task automatic test_false_com();
    do_reset();
    stim.delete();
    repeat (4) push_byte(BC);
    push_byte(8'h0B); push_byte(8'hC0); push_byte(8'h00);
    drive(0);
    run_model(4);
    for (int e = 0; e < stim.size(); e++) begin
      checks++;
      if (obs_act[e] !== exp_act[e] || obs_d[e] !== exp_d[e] || obs_v[e] !== exp_v[e]) begin
        failures++;
        $display("FAIL falsecom edge %0d: got a=%b d=%h v=%b, want a=%b d=%h v=%b", e, obs_act[e], obs_d[e], obs_v[e], exp_act[e], exp_d[e], exp_v[e]);
      end
    end
    checks++;
    if (obs_d[39] !== 8'h0B || obs_v[39] !== 1'b1 || obs_d[47] !== 8'hC0 || obs_v[47] !== 1'b1) begin
      failures++;
      $display("FAIL falsecom_key: got %h/%b %h/%b, want 0b/1 c0/1", obs_d[39], obs_v[39], obs_d[47], obs_v[47]);
    end
  endtask

  task automatic test_com_count1();
    logic [7:0] r;
    r = 8'($urandom);
    if (r == BC) r = 8'h3C;
    do_reset();
    stim.delete();
    push_byte(BC);
    push_byte(r);
    push_byte(8'($urandom));
    drive(1);
    run_model(1);
    for (int e = 0; e < stim.size(); e++) begin
      checks++;
      if (obs_act[e] !== exp_act[e] || obs_d[e] !== exp_d[e] || obs_v[e] !== exp_v[e]) begin
        failures++;
        $display("FAIL count1 edge %0d: got a=%b d=%h v=%b, want a=%b d=%h v=%b", e, obs_act[e], obs_d[e], obs_v[e], exp_act[e], exp_d[e], exp_v[e]);
      end
    end
    checks++;
    if (obs_act[6] !== 1'b0 || obs_act[7] !== 1'b1 || obs_d[15] !== r || obs_v[15] !== 1'b1) begin
      failures++;
      $display("FAIL count1_key: got a6=%b a7=%b d15=%h v15=%b, want 0 1 %h 1", obs_act[6], obs_act[7], obs_d[15], obs_v[15], r);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      do_reset();
      stim.delete();
      for (int j = $urandom_range(12, 0); j > 0; j--) stim.push_back(1'($urandom));
      for (int j = $urandom_range(5, 1); j > 0; j--) push_byte(BC);
      if ($urandom_range(1, 0) == 1) begin
        push_byte(8'($urandom));
        repeat (4) push_byte(BC);
      end
      for (int j = 0; j < 8; j++) push_byte(($urandom_range(3, 0) == 0) ? BC : 8'($urandom));
      drive(0);
      run_model(4);
      for (int e = 0; e < stim.size(); e++) begin
        checks++;
        if (obs_act[e] !== exp_act[e] || obs_d[e] !== exp_d[e] || obs_v[e] !== exp_v[e]) begin
          failures++;
          $display("FAIL random it %0d edge %0d: got a=%b d=%h v=%b, want a=%b d=%h v=%b", it, e, obs_act[e], obs_d[e], obs_v[e], exp_act[e], exp_d[e], exp_v[e]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock_offset3();
    test_broken_alignment();
    test_com_strip();
    test_false_com();
    test_com_count1();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
